// File: rtl/hamming_gmat_row_streamer.sv
// rtl/hamming_gmat_row_streamer.sv - streams systematic (extended) Hamming generator rows over valid/ready
// Rows are built from the candidate column index i (non powers of two), one row per handshake.
module hamming_gmat_row_streamer #(
    parameter int MAX_M = 5,
    parameter int IDXW  = MAX_M,
    parameter int W     = 2 ** MAX_M
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      m,
    input  logic            ext_en,
    input  logic            abort,
    output logic            row_valid,
    input  logic            row_ready,
    output logic [W-1:0]    row_data,
    output logic [IDXW-1:0] row_idx,
    output logic [IDXW-1:0] n_out,
    output logic [IDXW-1:0] k_out,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD, S_FIN} state_t;

    state_t          r_state;
    logic [3:0]      r_m;
    logic            r_ext;
    logic [IDXW:0]   r_i;
    logic [IDXW-1:0] r_row;
    logic [IDXW-1:0] r_n;
    logic [IDXW-1:0] r_k;

    logic            w_m_ok;
    logic [IDXW:0]   w_pow;
    logic [IDXW-1:0] w_n_new;
    logic [IDXW-1:0] w_k_new;
    logic            w_is_pow2;
    logic [W-1:0]    w_base;
    logic [W-1:0]    w_row;

    assign n_out = r_n;
    assign k_out = r_k;

    assign w_m_ok    = (m >= 4'd2) && (int'(m) <= MAX_M);
    assign w_pow     = (IDXW+1)'(1) << m;
    assign w_n_new   = IDXW'(w_pow - (IDXW+1)'(1));
    assign w_k_new   = w_n_new - IDXW'(m);
    assign w_is_pow2 = ((r_i & (r_i - (IDXW+1)'(1))) == '0);

    // Parity bits occupy k..n-1 with i's MSB first; k+m-1-b == n-1-b for bit b of i.
    always_comb begin
        w_base        = '0;
        w_base[r_row] = 1'b1;
        for (int b = 0; b < MAX_M; b++) begin
            if (b < int'(r_m)) begin
                w_base[r_n - IDXW'(1) - IDXW'(b)] = r_i[b];
            end
        end
        w_row = w_base;
        if (r_ext) begin
            w_row[r_n] = ^w_base;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_ext     <= 1'b0;
            r_i       <= '0;
            r_row     <= '0;
            r_n       <= '0;
            r_k       <= '0;
            row_valid <= 1'b0;
            row_data  <= '0;
            row_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_m_ok) begin
                            r_m     <= m;
                            r_ext   <= ext_en;
                            r_n     <= w_n_new;
                            r_k     <= w_k_new;
                            r_i     <= (IDXW+1)'(1);
                            r_row   <= '0;
                            busy    <= 1'b1;
                            r_state <= S_SCAN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        row_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (w_is_pow2) begin
                        r_i <= r_i + (IDXW+1)'(1);
                    end else begin
                        row_data  <= w_row;
                        row_idx   <= r_row;
                        row_valid <= 1'b1;
                        r_state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // abort takes priority over a same-cycle handshake, dropping the row
                    if (abort) begin
                        row_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (row_ready) begin
                        row_valid <= 1'b0;
                        if (r_row == r_k - IDXW'(1)) begin
                            r_state <= S_FIN;
                        end else begin
                            r_i     <= r_i + (IDXW+1)'(1);
                            r_row   <= r_row + IDXW'(1);
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_gmat_row_streamer.sv
// tb/tb_hamming_gmat_row_streamer.sv - directed checks of hamming_gmat_row_streamer
module tb_hamming_gmat_row_streamer;
    localparam int MAX_M = 5;
    localparam int IDXW  = 5;
    localparam int W     = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [3:0]      m;
    logic            ext_en;
    logic            abort;
    logic            row_valid;
    logic            row_ready;
    logic [W-1:0]    row_data;
    logic [IDXW-1:0] row_idx;
    logic [IDXW-1:0] n_out;
    logic [IDXW-1:0] k_out;
    logic            busy;
    logic            done;
    logic            err;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0]    got_data [64];
    logic [IDXW-1:0] got_idx  [64];

    hamming_gmat_row_streamer #(.MAX_M(MAX_M), .IDXW(IDXW)) dut (
        .clk(clk), .reset(reset), .start(start), .m(m), .ext_en(ext_en),
        .abort(abort), .row_valid(row_valid), .row_ready(row_ready),
        .row_data(row_data), .row_idx(row_idx), .n_out(n_out), .k_out(k_out),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start_run(input logic [3:0] mm, input logic ee);
        @(negedge clk);
        start  = 1'b1;
        m      = mm;
        ext_en = ee;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Called at the negedge after the start edge; returns rows and the cycle done was seen.
    task automatic collect(input bit rnd, output int nrows, output int done_cyc);
        logic            stalled;
        logic [W-1:0]    hd;
        logic [IDXW-1:0] hi;
        stalled  = 1'b0;
        hd       = '0;
        hi       = '0;
        nrows    = 0;
        done_cyc = -1;
        row_ready = 1'b1;
        for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) chk("busy_run", busy, 1);
            if (done) done_cyc = c;
            if (stalled) begin
                chk("stall_valid", row_valid, 1);
                chk("stall_data", row_data, hd);
                chk("stall_idx", row_idx, hi);
            end
            row_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (row_valid && row_ready) begin
                if (nrows < 64) begin
                    got_data[nrows] = row_data;
                    got_idx[nrows]  = row_idx;
                end
                nrows++;
            end
            stalled = row_valid && !row_ready;
            hd      = row_data;
            hi      = row_idx;
        end
        chk("done_seen", (done_cyc >= 0), 1);
        row_ready = 1'b1;
    endtask

    logic [W-1:0] exp3  [4];
    logic [W-1:0] exp3e [4];
    int nr, dc;
    bit found, done_any;

    initial begin
        exp3  = '{32'h61, 32'h52, 32'h34, 32'h78};
        exp3e = '{32'hE1, 32'hD2, 32'hB4, 32'h78};
        reset = 1'b1; start = 1'b0; m = '0; ext_en = 1'b0; abort = 1'b0; row_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", row_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_n", n_out, 0);
        chk("rst_k", k_out, 0);
        chk("rst_data", row_data, 0);
        reset = 1'b0;

        // m=3, no extension, ready held high
        start_run(4'd3, 1'b0);
        collect(1'b0, nr, dc);
        chk("m3_rows", nr, 4);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("m3_data%0d", r), got_data[r], exp3[r]);
            chk($sformatf("m3_idx%0d", r), got_idx[r], r);
        end
        chk("m3_lat", dc, 12);
        chk("m3_n", n_out, 7);
        chk("m3_k", k_out, 4);
        chk("m3_busy_fin", busy, 0);
        @(negedge clk);
        chk("m3_done_pulse", done, 0);

        // m=3 extended
        start_run(4'd3, 1'b1);
        collect(1'b0, nr, dc);
        chk("m3e_rows", nr, 4);
        for (int r = 0; r < 4; r++) chk($sformatf("m3e_data%0d", r), got_data[r], exp3e[r]);

        // m=2 extended: single row
        start_run(4'd2, 1'b1);
        collect(1'b0, nr, dc);
        chk("m2_rows", nr, 1);
        chk("m2_data", got_data[0], 32'hF);
        chk("m2_idx", got_idx[0], 0);
        chk("m2_n", n_out, 3);
        chk("m2_k", k_out, 1);
        chk("m2_lat", dc, 5);

        // m=3 with random backpressure
        start_run(4'd3, 1'b0);
        collect(1'b1, nr, dc);
        chk("bp_rows", nr, 4);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("bp_data%0d", r), got_data[r], exp3[r]);
            chk($sformatf("bp_idx%0d", r), got_idx[r], r);
        end

        // invalid orders
        start_run(4'd1, 1'b0);
        chk("m1_err", err, 1);
        chk("m1_busy", busy, 0);
        chk("m1_n", n_out, 7);
        chk("m1_k", k_out, 4);
        @(negedge clk);
        chk("m1_err_clr", err, 0);
        start_run(4'd6, 1'b0);
        chk("m6_err", err, 1);
        chk("m6_busy", busy, 0);
        chk("m6_n", n_out, 7);
        @(negedge clk);
        chk("m6_err_clr", err, 0);

        // m=5 extended: 26 rows
        start_run(4'd5, 1'b1);
        collect(1'b0, nr, dc);
        chk("m5_rows", nr, 26);
        chk("m5_row0", got_data[0], 32'hE000_0001);
        chk("m5_row25", got_data[25], 32'h7E00_0000);
        chk("m5_idx25", got_idx[25], 25);
        chk("m5_n", n_out, 31);
        chk("m5_k", k_out, 26);
        chk("m5_lat", dc, 58);

        // abort while row 10 is offered and ready is high
        start_run(4'd5, 1'b0);
        row_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (row_valid && row_idx == 5'd10) begin
                abort = 1'b1;
                found = 1'b1;
            end
        end
        chk("abort_reached", found, 1);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", row_valid, 0);
        chk("abort_busy", busy, 0);
        done_any = done;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            done_any = done_any | done;
        end
        chk("abort_no_done", done_any, 0);
        start_run(4'd3, 1'b0);
        collect(1'b0, nr, dc);
        chk("post_abort_rows", nr, 4);
        for (int r = 0; r < 4; r++) chk($sformatf("pa_data%0d", r), got_data[r], exp3[r]);
        chk("post_abort_lat", dc, 12);

        // asynchronous reset while holding a row
        row_ready = 1'b0;
        start_run(4'd3, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (row_valid) found = 1'b1;
        end
        chk("hold_reached", found, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", row_valid, 0);
        chk("arst_data", row_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_n", n_out, 0);
        chk("arst_k", k_out, 0);
        @(negedge clk);
        reset = 1'b0;
        row_ready = 1'b1;
        @(negedge clk);
        chk("arst_after", row_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
